// File: rtl/store_buffer_sz.sv
// ---------------------------------------------------------------------------
// store_buffer_sz
//   Store buffer sitting between the MEM stage and data memory. Stores
//   (sw/sb/sh) are lane-aligned with byte enables, queued in a small FIFO,
//   and drained to memory over a valid/ready write port. This lets the
//   pipeline retire stores without waiting on memory. BufEmpty tells the
//   load path when no stores are still in flight.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   StoreEnM     store request valid from the MEM stage
//   StoreSize    00=sw, 01=sb, 10=sh, 11=illegal
//   AddrM        byte address
//   WriteDataM   store data; byte/half in the low bits
//   StoreReadyM  buffer can accept a request (not full)
//   MisalignM    one-cycle pulse: the previous-cycle request was rejected
//   BufEmpty     no entries queued
//   MemWrValid   head entry valid toward memory
//   MemWrReady   memory accepts the head entry this cycle
//   MemAddr      word-aligned address of the head entry
//   MemWrData    lane-aligned data of the head entry
//   MemByteEn    byte enables of the head entry, bit i = byte lane i
// ---------------------------------------------------------------------------
module store_buffer_sz #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StoreEnM,
  input  logic [1:0]    StoreSize,
  input  logic [AW-1:0] AddrM,
  input  logic [31:0]   WriteDataM,
  output logic          StoreReadyM,
  output logic          MisalignM,
  output logic          BufEmpty,
  output logic          MemWrValid,
  input  logic          MemWrReady,
  output logic [AW-1:0] MemAddr,
  output logic [31:0]   MemWrData,
  output logic [3:0]    MemByteEn
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_B = 2'b01;
  localparam logic [1:0] SZ_H = 2'b10;

  // FIFO storage
  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    en_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_q;
  logic          misalign_q;

  // Formatted request
  logic [1:0]    lane;
  logic [31:0]   fmt_data;
  logic [3:0]    fmt_en;
  logic          fmt_legal;
  logic [AW-1:0] word_addr;

  logic enq, rej, deq;

  assign lane      = AddrM[1:0];
  assign word_addr = {AddrM[AW-1:2], 2'b00};

  always_comb begin
    fmt_data  = WriteDataM;
    fmt_en    = 4'b0000;
    fmt_legal = 1'b0;
    case (StoreSize)
      SZ_W: begin
        fmt_data  = WriteDataM;
        fmt_en    = 4'b1111;
        fmt_legal = (lane == 2'b00);
      end
      SZ_B: begin
        fmt_data  = {4{WriteDataM[7:0]}};
        fmt_en    = 4'b0001 << lane;
        fmt_legal = 1'b1;
      end
      SZ_H: begin
        fmt_data  = {2{WriteDataM[15:0]}};
        fmt_en    = lane[1] ? 4'b1100 : 4'b0011;
        fmt_legal = ~lane[0];
      end
      default: begin
        fmt_data  = WriteDataM;
        fmt_en    = 4'b0000;
        fmt_legal = 1'b0;
      end
    endcase
  end

  // Requests arriving while full are ignored entirely; the pipeline holds them.
  assign enq = StoreEnM & StoreReadyM & fmt_legal;
  assign rej = StoreEnM & StoreReadyM & ~fmt_legal;
  assign deq = MemWrValid & MemWrReady;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      misalign_q <= 1'b0;
      // Clearing the storage keeps the head outputs at zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        en_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      misalign_q <= rej;
      if (enq) begin
        addr_q[wr_ptr_q] <= word_addr;
        data_q[wr_ptr_q] <= fmt_data;
        en_q[wr_ptr_q]   <= fmt_en;
      end
    end
  end

  assign StoreReadyM = ~full_q;
  assign MisalignM   = misalign_q;
  assign BufEmpty    = (count_q == '0);
  assign MemWrValid  = ~BufEmpty;
  assign MemAddr     = addr_q[rd_ptr_q];
  assign MemWrData   = data_q[rd_ptr_q];
  assign MemByteEn   = en_q[rd_ptr_q];

endmodule

// File: tb/tb_store_buffer_sz.sv
module tb_store_buffer_sz;

  logic        clk;
  logic        reset;
  logic        StoreEnM;
  logic [1:0]  StoreSize;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        StoreReadyM;
  logic        MisalignM;
  logic        BufEmpty;
  logic        MemWrValid;
  logic        MemWrReady;
  logic [31:0] MemAddr;
  logic [31:0] MemWrData;
  logic [3:0]  MemByteEn;

  int tests = 0;
  int fails = 0;
  int deq_cnt = 0;

  logic [67:0] sb_q [$];

  store_buffer_sz #(.DEPTH(4), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .StoreEnM   (StoreEnM),
    .StoreSize  (StoreSize),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .StoreReadyM(StoreReadyM),
    .MisalignM  (MisalignM),
    .BufEmpty   (BufEmpty),
    .MemWrValid (MemWrValid),
    .MemWrReady (MemWrReady),
    .MemAddr    (MemAddr),
    .MemWrData  (MemWrData),
    .MemByteEn  (MemByteEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Expected memory beat {word addr, data, byte enables}; returns legality.
  function automatic logic fmt(input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, output logic [67:0] e);
    logic [31:0] wa;
    logic [3:0]  en;
    wa = {a[31:2], 2'b00};
    e  = '0;
    case (sz)
      2'b00: begin
        e = {wa, wd, 4'b1111};
        return (a[1:0] == 2'b00);
      end
      2'b01: begin
        case (a[1:0])
          2'd0: en = 4'b0001;
          2'd1: en = 4'b0010;
          2'd2: en = 4'b0100;
          default: en = 4'b1000;
        endcase
        e = {wa, wd[7:0], wd[7:0], wd[7:0], wd[7:0], en};
        return 1'b1;
      end
      2'b10: begin
        en = a[1] ? 4'b1100 : 4'b0011;
        e  = {wa, wd[15:0], wd[15:0], en};
        return (a[0] == 1'b0);
      end
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard consumer: compares every beat memory accepts.
  always @(negedge clk) begin
    logic [67:0] got, exp_b;
    if (!reset && MemWrValid === 1'b1 && MemWrReady === 1'b1) begin
      got = {MemAddr, MemWrData, MemByteEn};
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat got=%h expected none", got);
      end else begin
        exp_b = sb_q.pop_front();
        if (got !== exp_b) begin
          fails++;
          $display("FAIL beat got addr=%h data=%h en=%b expected addr=%h data=%h en=%b",
                   got[67:36], got[35:4], got[3:0], exp_b[67:36], exp_b[35:4], exp_b[3:0]);
        end
      end
      deq_cnt++;
    end
  end

  // Presents one request at posedge+1 once the buffer is ready; returns
  // at posedge+1 after the accepting edge with StoreEnM dropped.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [67:0] e;
    logic legal;
    int c;
    c = 0;
    while (StoreReadyM !== 1'b1 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (StoreReadyM !== 1'b1) begin
      tests++; fails++;
      $display("FAIL store_ready_timeout got=%b expected 1", StoreReadyM);
    end
    StoreEnM   = 1'b1;
    StoreSize  = sz;
    AddrM      = a;
    WriteDataM = wd;
    legal = fmt(sz, a, wd, e);
    if (legal) sb_q.push_back(e);
    @(posedge clk); #1;
    StoreEnM = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 100; c++) begin
      if (sb_q.size() == 0 && BufEmpty === 1'b1) break;
      @(posedge clk); #1;
    end
    tests++;
    if (sb_q.size() != 0 || BufEmpty !== 1'b1) begin
      fails++;
      $display("FAIL %s_drain pending=%0d BufEmpty=%b expected 0 and 1", name, sb_q.size(), BufEmpty);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s got=%b expected=%b", name, got, exp_v);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check1("reset_ready", StoreReadyM, 1'b1);
    check1("reset_empty", BufEmpty, 1'b1);
    check1("reset_misalign", MisalignM, 1'b0);
    check1("reset_valid", MemWrValid, 1'b0);
    tests++;
    if ({MemAddr, MemWrData, MemByteEn} !== 68'h0) begin
      fails++;
      $display("FAIL reset_head got addr=%h data=%h en=%b expected zeros", MemAddr, MemWrData, MemByteEn);
    end
  endtask

  task automatic test_sw;
    int d0;
    MemWrReady = 1'b1;
    d0 = deq_cnt;
    do_store(2'b00, 32'h100, 32'hDEADBEEF);
    check1("sw_visible_next_cycle", MemWrValid, 1'b1);
    wait_drain("sw");
    tests++;
    if (deq_cnt - d0 != 1) begin
      fails++;
      $display("FAIL sw_beats got=%0d expected=1", deq_cnt - d0);
    end
  endtask

  task automatic test_sb_sh;
    do_store(2'b01, 32'h203, 32'h000000A5);
    do_store(2'b01, 32'h201, 32'h0000005A);
    do_store(2'b01, 32'h200, 32'h11223344);
    do_store(2'b10, 32'h302, 32'h00001234);
    do_store(2'b10, 32'h300, 32'hABCD9876);
    wait_drain("sb_sh");
  endtask

  task automatic test_reject(input string name, input logic [1:0] sz, input logic [31:0] a);
    do_store(sz, a, 32'h55AA55AA);
    @(negedge clk);
    check1({name, "_pulse"}, MisalignM, 1'b1);
    check1({name, "_empty"}, BufEmpty, 1'b1);
    @(negedge clk);
    check1({name, "_pulse_end"}, MisalignM, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_full;
    int d0;
    MemWrReady = 1'b0;
    for (int k = 1; k <= 4; k++) do_store(2'b00, 32'h400 + 32'(4 * (k - 1)), 32'(k));
    check1("full_not_ready", StoreReadyM, 1'b0);
    // Fifth request held while full must not enter the queue.
    StoreEnM = 1'b1; StoreSize = 2'b00; AddrM = 32'h500; WriteDataM = 32'h5;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check1("full_hold_not_ready", StoreReadyM, 1'b0);
      tests++;
      if (MemWrData !== 32'h1 || MemAddr !== 32'h400) begin
        fails++;
        $display("FAIL full_head_stable got addr=%h data=%h expected 400/1", MemAddr, MemWrData);
      end
    end
    StoreEnM = 1'b0;
    d0 = deq_cnt;
    MemWrReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check1("full_drain_consecutive", MemWrValid, 1'b1);
    end
    @(posedge clk); #1;
    check1("full_empty_after", BufEmpty, 1'b1);
    wait_drain("full");
    tests++;
    if (deq_cnt - d0 != 4) begin
      fails++;
      $display("FAIL full_beats got=%0d expected=4", deq_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    logic [67:0] e;
    logic [1:0] sz;
    logic [31:0] a;
    MemWrReady = 1'b1;
    d0 = deq_cnt;
    for (int i = 0; i < 20; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom & 32'h0000FFFF;
      if (sz == 2'b00) a[1:0] = 2'b00;
      if (sz == 2'b10) a[0] = 1'b0;
      StoreEnM = 1'b1; StoreSize = sz; AddrM = a; WriteDataM = $urandom;
      check1("b2b_ready", StoreReadyM, 1'b1);
      if (i > 0) check1("b2b_one_entry", BufEmpty, 1'b0);
      if (fmt(sz, a, WriteDataM, e)) sb_q.push_back(e);
      @(posedge clk); #1;
    end
    StoreEnM = 1'b0;
    wait_drain("b2b");
    tests++;
    if (deq_cnt - d0 != 20) begin
      fails++;
      $display("FAIL b2b_beats got=%0d expected=20", deq_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    MemWrReady = 1'b0;
    for (int k = 0; k < 3; k++) do_store(2'b00, 32'h700 + 32'(4 * k), 32'hA0 + 32'(k));
    check1("mid_not_empty", BufEmpty, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check1("mid_valid", MemWrValid, 1'b0);
    check1("mid_empty", BufEmpty, 1'b1);
    check1("mid_ready", StoreReadyM, 1'b1);
    sb_q.delete();
    MemWrReady = 1'b1;
    d0 = deq_cnt;
    do_store(2'b00, 32'h600, 32'hCAFEF00D);
    wait_drain("mid");
    tests++;
    if (deq_cnt - d0 != 1) begin
      fails++;
      $display("FAIL mid_beats got=%0d expected=1", deq_cnt - d0);
    end
  endtask

  initial begin
    reset = 1'b1; StoreEnM = 1'b0; StoreSize = 2'b00; AddrM = '0;
    WriteDataM = '0; MemWrReady = 1'b0;
    test_reset;
    test_sw;
    test_sb_sh;
    test_reject("sh_misalign", 2'b10, 32'h301);
    test_reject("sw_misalign", 2'b00, 32'h102);
    test_reject("size_illegal", 2'b11, 32'h100);
    test_full;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
